// File: rtl/pwm_hue_ctrl.sv
// pwm_hue_ctrl: button-stepped duty/hue PWM with main output plus R/G/B
// channels derived from a six-sector colour wheel. Buttons are synchronised,
// edge-detected and optionally auto-repeated. Levels take effect only at the
// period boundary, and all PWM outputs are registered.
// Optional macro PWM_BREATHE_EN adds a 'breathe' input that ramps the duty
// as a triangle wave, one STEP per period.
module pwm_hue_ctrl #(
    parameter int CNT_W       = 8,
    parameter int PERIOD      = 120,
    parameter int STEP        = 5,
    parameter int DUTY_INIT   = 30,
    parameter int SYNC_STAGES = 2,
    parameter int REPEAT_DLY  = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec,
`ifdef PWM_BREATHE_EN
    input  logic             breathe,
`endif
    output logic [CNT_W-1:0] duty_o,
    output logic             period_start,
    output logic             out_main,
    output logic             out_r,
    output logic             out_g,
    output logic             out_b
);

    localparam int SEG    = PERIOD / 6;
    localparam int HOLD_W = (REPEAT_DLY > 0) ? $clog2(REPEAT_DLY + 1) : 1;
    localparam logic [CNT_W-1:0]  PER   = CNT_W'(PERIOD);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(PERIOD - 1);
    localparam logic [HOLD_W-1:0] DLY_V = HOLD_W'(REPEAT_DLY);

    // Colour wheel: sector k and offset found by comparison against sector
    // bases, so no divider is needed. Returns {r, g, b}.
    function automatic logic [3*CNT_W-1:0] hue_rgb(input logic [CNT_W-1:0] d);
        logic [2:0]       k;
        logic [CNT_W-1:0] base, ramp, r, g, b;
        k    = '0;
        base = '0;
        for (int i = 1; i < 6; i++) begin
            if (d >= CNT_W'(i * SEG)) begin
                k    = 3'(i);
                base = CNT_W'(i * SEG);
            end
        end
        ramp = (d - base) * CNT_W'(6);
        case (k)
            3'd0:    begin r = PER;        g = ramp;       b = '0;         end
            3'd1:    begin r = PER - ramp; g = PER;        b = '0;         end
            3'd2:    begin r = '0;         g = PER;        b = ramp;       end
            3'd3:    begin r = '0;         g = PER - ramp; b = PER;        end
            3'd4:    begin r = ramp;       g = '0;         b = PER;        end
            default: begin r = PER;        g = '0;         b = PER - ramp; end
        endcase
        if (d == '0) begin
            r = '0; g = '0; b = '0;
        end else if (d == PER) begin
            r = PER; g = PER; b = PER;
        end
        return {r, g, b};
    endfunction

    localparam logic [3*CNT_W-1:0] INIT_RGB = hue_rgb(CNT_W'(DUTY_INIT));

    // Button path: index 0 = inc, index 1 = dec
    logic [1:0]             btn_raw, btn_s, btn_ev, btn_prev_q, btn_prev_d;
    logic [SYNC_STAGES-1:0] sync_q [2];
    logic [SYNC_STAGES-1:0] sync_d [2];
    logic [HOLD_W-1:0]      hold_q [2];
    logic [HOLD_W-1:0]      hold_d [2];

    logic [CNT_W-1:0] cnt_q, cnt_d, duty_q, duty_d;
    logic [CNT_W-1:0] lvl_m_q, lvl_m_d, lvl_r_q, lvl_r_d, lvl_g_q, lvl_g_d, lvl_b_q, lvl_b_d;
    logic [CNT_W-1:0] col_r, col_g, col_b, up_val, dn_val;
    logic [CNT_W:0]   sum, diff;
    logic period_start_q, period_start_d;
    logic out_main_q, out_main_d, out_r_q, out_r_d, out_g_q, out_g_d, out_b_q, out_b_d;

`ifdef PWM_BREATHE_EN
    logic [SYNC_STAGES-1:0] brth_sync_q, brth_sync_d;
    logic brth_s, dir_up_q, dir_up_d, up_now;
`endif

    assign btn_raw = {dec, inc};

    // Synchroniser shift, rising-edge detect and auto-repeat hold counters
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            sync_d[i]     = {sync_q[i][SYNC_STAGES-2:0], btn_raw[i]};
            btn_s[i]      = sync_q[i][SYNC_STAGES-1];
            btn_prev_d[i] = btn_s[i];
            btn_ev[i]     = btn_s[i] & ~btn_prev_q[i];
            hold_d[i]     = '0;
            if (REPEAT_DLY > 0 && btn_s[i]) begin
                if (!btn_prev_q[i]) begin
                    hold_d[i] = HOLD_W'(1);
                end else if (hold_q[i] == DLY_V) begin
                    btn_ev[i] = 1'b1;
                    hold_d[i] = HOLD_W'(1);
                end else begin
                    hold_d[i] = hold_q[i] + HOLD_W'(1);
                end
            end
        end
    end

    // Saturating duty update, one bit wider so nothing wraps
    always_comb begin
        sum    = {1'b0, duty_q} + (CNT_W+1)'(STEP);
        diff   = {1'b0, duty_q} - (CNT_W+1)'(STEP);
        up_val = (sum > (CNT_W+1)'(PERIOD)) ? PER : sum[CNT_W-1:0];
        dn_val = diff[CNT_W] ? '0 : diff[CNT_W-1:0];
        duty_d = duty_q;
        if (btn_ev[0] && !btn_ev[1]) begin
            duty_d = up_val;
        end else if (btn_ev[1] && !btn_ev[0]) begin
            duty_d = dn_val;
        end
`ifdef PWM_BREATHE_EN
        brth_sync_d = {brth_sync_q[SYNC_STAGES-2:0], breathe};
        brth_s      = brth_sync_q[SYNC_STAGES-1];
        up_now      = dir_up_q ? (duty_q != PER) : (duty_q == '0);
        dir_up_d    = 1'b1;
        if (brth_s) begin
            // Buttons are ignored; turn around at either end of the ramp
            duty_d   = duty_q;
            dir_up_d = dir_up_q;
            if (cnt_q == LAST) begin
                duty_d   = up_now ? up_val : dn_val;
                dir_up_d = up_now;
            end
        end
`endif
    end

    // Period counter, boundary pulse, shadow level load and PWM compare
    always_comb begin
        cnt_d          = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
        period_start_d = (cnt_d == '0);
        {col_r, col_g, col_b} = hue_rgb(duty_q);
        lvl_m_d = lvl_m_q;
        lvl_r_d = lvl_r_q;
        lvl_g_d = lvl_g_q;
        lvl_b_d = lvl_b_q;
        if (cnt_q == LAST) begin
            lvl_m_d = duty_q;
            lvl_r_d = col_r;
            lvl_g_d = col_g;
            lvl_b_d = col_b;
        end
        out_main_d = (cnt_q < lvl_m_q);
        out_r_d    = (cnt_q < lvl_r_q);
        out_g_d    = (cnt_q < lvl_g_q);
        out_b_d    = (cnt_q < lvl_b_q);
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                sync_q[i] <= '0;
                hold_q[i] <= '0;
            end
            btn_prev_q     <= '0;
            cnt_q          <= '0;
            duty_q         <= CNT_W'(DUTY_INIT);
            lvl_m_q        <= CNT_W'(DUTY_INIT);
            lvl_r_q        <= INIT_RGB[3*CNT_W-1:2*CNT_W];
            lvl_g_q        <= INIT_RGB[2*CNT_W-1:CNT_W];
            lvl_b_q        <= INIT_RGB[CNT_W-1:0];
            period_start_q <= 1'b0;
            out_main_q     <= 1'b0;
            out_r_q        <= 1'b0;
            out_g_q        <= 1'b0;
            out_b_q        <= 1'b0;
`ifdef PWM_BREATHE_EN
            brth_sync_q    <= '0;
            dir_up_q       <= 1'b1;
`endif
        end else begin
            for (int i = 0; i < 2; i++) begin
                sync_q[i] <= sync_d[i];
                hold_q[i] <= hold_d[i];
            end
            btn_prev_q     <= btn_prev_d;
            cnt_q          <= cnt_d;
            duty_q         <= duty_d;
            lvl_m_q        <= lvl_m_d;
            lvl_r_q        <= lvl_r_d;
            lvl_g_q        <= lvl_g_d;
            lvl_b_q        <= lvl_b_d;
            period_start_q <= period_start_d;
            out_main_q     <= out_main_d;
            out_r_q        <= out_r_d;
            out_g_q        <= out_g_d;
            out_b_q        <= out_b_d;
`ifdef PWM_BREATHE_EN
            brth_sync_q    <= brth_sync_d;
            dir_up_q       <= dir_up_d;
`endif
        end
    end

    assign duty_o       = duty_q;
    assign period_start = period_start_q;
    assign out_main     = out_main_q;
    assign out_r        = out_r_q;
    assign out_g        = out_g_q;
    assign out_b        = out_b_q;

endmodule

// File: doc/pwm_hue_ctrl.md
Name: pwm_hue_ctrl

Overview:
- Parametrised successor of the single-channel button-driven PWM with fixed RGB colour table.
- One main PWM output plus R/G/B outputs. A push-button pair steps a saturating duty/hue value.
- RGB levels come from an arithmetic six-sector colour wheel instead of a lookup table.
- Adds synchronised inputs, auto-repeat, glitch-free period-boundary updates and registered outputs; drives LED pins at top level.

Parameters:
- CNT_W, 8: width of counter, duty and level registers; must satisfy 2^CNT_W > PERIOD.
- PERIOD, 120: PWM period in clk cycles; must be a multiple of 6.
- STEP, 5: duty change per button event; 1 <= STEP <= PERIOD.
- DUTY_INIT, 30: duty after reset; 0 <= DUTY_INIT <= PERIOD.
- SYNC_STAGES, 2: synchroniser flops per button input; minimum 2.
- REPEAT_DLY, 0: hold cycles per auto-repeat event; 0 disables auto-repeat.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- inc  in  1  raw button, increase duty by STEP
- dec  in  1  raw button, decrease duty by STEP
- duty_o  out  CNT_W  current (pending) duty value
- period_start  out  1  one-cycle pulse when counter is 0
- out_main  out  1  PWM at active duty
- out_r  out  1  PWM red channel
- out_g  out  1  PWM green channel
- out_b  out  1  PWM blue channel

Behaviour:
- Reset: clk, single domain; rst_n asynchronous active-low. In reset, counter=0, duty=DUTY_INIT, and shadow levels hold DUTY_INIT's main level and colour. All PWM outputs and period_start are 0, duty_o=DUTY_INIT. Assertion mid-period forces outputs 0 immediately.
- Input sync: inc and dec each pass through SYNC_STAGES flops, then a rising-edge detect produces one-cycle inc_ev/dec_ev.
- Auto-repeat (REPEAT_DLY>0): while the synchronised button stays high, a hold counter raises an extra event every REPEAT_DLY cycles after the edge. Release clears the hold counter.
- Duty update, applied in the cycle after the event:
  - inc_ev only: duty=min(duty+STEP, PERIOD).
  - dec_ev only: duty=max(duty-STEP, 0).
  - Both in the same cycle: no change.
  - Arithmetic is done one bit wider, so there is no wrap-around.
- Counter: counts 0..PERIOD-1 by 1, then wraps to 0. period_start is registered and high for the cycle in which the counter equals 0.
- Shadow update: at the cycle where counter==PERIOD-1, the active main level and r/g/b levels load from duty and its colour. Mid-period duty changes never alter pulse widths within the current period.
- Colour mapping, with SEG=PERIOD/6, k=duty/SEG, o=duty%SEG, ramp=o*6:
  - duty==0: R=G=B=0.
  - duty==PERIOD: R=G=B=PERIOD (white).
  - k=0: R=PERIOD, G=ramp, B=0.
  - k=1: R=PERIOD-ramp, G=PERIOD, B=0.
  - k=2: R=0, G=PERIOD, B=ramp.
  - k=3: R=0, G=PERIOD-ramp, B=PERIOD.
  - k=4: R=ramp, G=0, B=PERIOD.
  - k=5: R=PERIOD, G=0, B=PERIOD-ramp.
  - k and o are derived combinationally by comparison/subtraction; no generic divider.
- Outputs are registered: out_x <= (counter < level_x). This gives one cycle of latency from the counter. Level 0 gives a constant 0; level PERIOD gives a constant 1.
- Input-to-width latency: SYNC_STAGES+1 cycles to duty_o, then the next period boundary to the output pulse width.

Optional Feature:
- Macro: PWM_BREATHE_EN.
- Defined: adds input breathe (1 bit, synchronised like the buttons). While it is high, inc/dec events are ignored and duty ramps by STEP once per period (at the shadow-load point). The ramp runs up to PERIOD, then down to 0, then up again (triangle). On deassertion, duty holds its current value and the direction flag resets to "up".
- Not defined: no breathe port and no ramp logic; behaviour exactly as above.

Test Plan:
1. Reset behaviour, defaults: release rst_n -> out_main high 30 of every 120 cycles, out_r 60, out_g 120, out_b 0. Assert rst_n mid-period -> all outputs 0 at once, duty_o=30.
2. Single press: inc held 3 cycles -> duty_o=35 exactly SYNC_STAGES+1 cycles after the rising edge. out_main width stays 30 until the next period_start, then becomes 35.
3. Saturation: 18 inc presses from 30 -> duty_o=120, all four outputs constantly 1, further inc leaves 120. 24 dec presses -> duty_o=0, all outputs constantly 0, further dec leaves 0.
4. Colour sector: step duty to 65 -> out_r 0, out_g 90, out_b 120 cycles per period. Duty 85 -> R=30, G=0, B=120.
5. Simultaneous and repeat: inc and dec rising in the same cycle -> duty unchanged. With REPEAT_DLY=16, inc held 100 cycles -> 1+6=7 events, duty 30->65.
6. PWM_BREATHE_EN: breathe held from duty=110 -> duty 115, 120, 115, ... one step per period. Release at 100 -> stays 100, inc -> 105.
